// File: rtl/recon_sched_pkg.sv
// Purpose: shared constants for the millisecond delay scheduler (address map, bit positions, FSM encoding).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package recon_sched_pkg;

    // Global register word addresses
    localparam logic [4:0] STATUS_OFFSET  = 5'd0;
    localparam logic [4:0] IRQ_ENA_OFFSET = 5'd1;

    // Channel window: channel i occupies words CH_BASE + CH_STRIDE*i .. +3
    localparam logic [4:0] CH_BASE   = 5'd8;
    localparam int         CH_STRIDE = 4;
    localparam logic [1:0] LOAD_OFF  = 2'd0;
    localparam logic [1:0] COUNT_OFF = 2'd1;
    localparam logic [1:0] CTRL_OFF  = 2'd2;

    // Register bit positions
    localparam int EN_BIT       = 0;
    localparam int PERIODIC_BIT = 1;
    localparam int OVERRUN_BIT  = 31;

    // Scan FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/recon_delay_sched_if.sv
// Purpose: Avalon-MM slave bus bundle for the delay scheduler register bank.
// Latency: readdata is registered, valid the cycle after chipselect&&read.
// Backpressure: none; the slave accepts every access in a single cycle.
// Ports: address[4:0], chipselect, write, read, writedata[31:0] from master; readdata[31:0] to master.
interface recon_delay_sched_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write, read, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, read, writedata,
        output readdata
    );
endinterface

// File: rtl/recon_delay_sched.sv
// Purpose: NUM_CH one-shot/periodic ms countdowns sharing one decrementer, scanned once per millisec_tick.
// Latency: a scan takes NUM_CH cycles; expire/STATUS follow the channel's scan cycle by one clock, irq by two.
// Backpressure: none; a tick during a scan is queued once, a further tick is dropped and flags OVERRUN.
// Ports: clk, reset_n (async active-low), bus (Avalon-MM slave), millisec_tick in,
//        expire[NUM_CH-1:0] per-channel pulse out, irq level out.
module recon_delay_sched
    import recon_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    recon_delay_sched_if.slave  bus,
    input  logic                millisec_tick,
    output logic [NUM_CH-1:0]   expire,
    output logic                irq
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // State
    logic [0:0]        state_q,     state_d;
    logic [IDX_W-1:0]  ch_idx_q,    ch_idx_d;
    logic              tick_pend_q, tick_pend_d;
    logic [CNT_W-1:0]  load_q  [NUM_CH];
    logic [CNT_W-1:0]  load_d  [NUM_CH];
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] en_q,      en_d;
    logic [NUM_CH-1:0] per_q,     per_d;
    logic [NUM_CH-1:0] status_q,  status_d;
    logic [NUM_CH-1:0] irq_ena_q, irq_ena_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [NUM_CH-1:0] expire_q,  expire_d;
    logic              irq_q,     irq_d;

    // Bus decode
    logic              bus_wr;
    logic              bus_rd;
    logic [4:0]        ch_off;
    logic [2:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic              ch_hit;
    logic [NUM_CH-1:0] wr_load;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [31:0]       rd_val;
    logic [NUM_CH-1:0] status_set;
    logic              overrun_set;
    logic [NUM_CH-1:0] w1c_mask;

    // Writedata bits above CNT_W / NUM_CH have no home in narrower builds.
    logic unused_wd;
    assign unused_wd = &{1'b0, bus.writedata};

    always_comb begin
        bus_wr  = bus.chipselect && bus.write;
        bus_rd  = bus.chipselect && bus.read;
        // Channel window is CH_STRIDE (4) words per channel: upper bits select channel.
        ch_off  = bus.address - CH_BASE;
        ch_sel  = ch_off[4:2];
        reg_sel = ch_off[1:0];
        ch_hit  = (bus.address >= CH_BASE) && (int'(ch_sel) < NUM_CH);

        for (int i = 0; i < NUM_CH; i++) begin
            wr_load[i] = bus_wr && ch_hit && (ch_sel == 3'(i)) && (reg_sel == LOAD_OFF);
            wr_ctrl[i] = bus_wr && ch_hit && (ch_sel == 3'(i)) && (reg_sel == CTRL_OFF);
        end
    end

    // Scan FSM plus channel update
    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        tick_pend_d = tick_pend_q;
        load_d      = load_q;
        count_d     = count_q;
        en_d        = en_q;
        per_d       = per_q;
        irq_ena_d   = irq_ena_q;
        expire_d    = '0;
        status_set  = '0;
        overrun_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (millisec_tick || tick_pend_q) begin
                    state_d  = ST_SCAN;
                    ch_idx_d = '0;
                    // A fresh tick arriving while a queued one is being consumed stays queued.
                    tick_pend_d = millisec_tick && tick_pend_q;
                end
            end
            default: begin
                if (millisec_tick) begin
                    if (tick_pend_q) overrun_set = 1'b1;
                    else             tick_pend_d = 1'b1;
                end
                if (ch_idx_q == IDX_W'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_idx_d = ch_idx_q + 1'b1;
                end
            end
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            // CPU writes to LOAD/CTRL override the scan result for that channel this cycle.
            if ((state_q == ST_SCAN) && (ch_idx_q == IDX_W'(i)) && en_q[i]
                && !wr_load[i] && !wr_ctrl[i]) begin
                if (count_q[i] > CNT_W'(1)) begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end else begin
                    status_set[i] = 1'b1;
                    expire_d[i]   = 1'b1;
                    if (per_q[i]) begin
                        count_d[i] = (load_q[i] == '0) ? CNT_W'(1) : load_q[i];
                    end else begin
                        count_d[i] = '0;
                        en_d[i]    = 1'b0;
                    end
                end
            end
            if (wr_load[i]) begin
                load_d[i] = bus.writedata[CNT_W-1:0];
            end
            if (wr_ctrl[i]) begin
                en_d[i]  = bus.writedata[EN_BIT];
                per_d[i] = bus.writedata[PERIODIC_BIT];
                if (bus.writedata[EN_BIT]) begin
                    count_d[i] = (load_q[i] == '0) ? CNT_W'(1) : load_q[i];
                end
            end
        end

        if (bus_wr && (bus.address == IRQ_ENA_OFFSET)) begin
            irq_ena_d = bus.writedata[NUM_CH-1:0];
        end
    end

    // STATUS / OVERRUN: write-1-to-clear, a same-cycle set takes priority.
    always_comb begin
        w1c_mask  = '0;
        if (bus_wr && (bus.address == STATUS_OFFSET)) begin
            w1c_mask = bus.writedata[NUM_CH-1:0];
        end
        status_d  = (status_q & ~w1c_mask) | status_set;
        overrun_d = (overrun_q & ~(bus_wr && (bus.address == STATUS_OFFSET)
                                   && bus.writedata[OVERRUN_BIT])) | overrun_set;
        irq_d     = |(status_q & irq_ena_q);
    end

    // Read mux; readdata holds between reads.
    always_comb begin
        rd_val = '0;
        if (bus.address == STATUS_OFFSET) begin
            rd_val[NUM_CH-1:0]  = status_q;
            rd_val[OVERRUN_BIT] = overrun_q;
        end else if (bus.address == IRQ_ENA_OFFSET) begin
            rd_val[NUM_CH-1:0] = irq_ena_q;
        end else if (ch_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 3'(i)) begin
                    case (reg_sel)
                        LOAD_OFF:  rd_val = 32'(load_q[i]);
                        COUNT_OFF: rd_val = 32'(count_q[i]);
                        CTRL_OFF: begin
                            rd_val[EN_BIT]       = en_q[i];
                            rd_val[PERIODIC_BIT] = per_q[i];
                        end
                        default:   rd_val = '0;
                    endcase
                end
            end
        end
        readdata_d = bus_rd ? rd_val : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ch_idx_q    <= '0;
            tick_pend_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
            end
            en_q        <= '0;
            per_q       <= '0;
            status_q    <= '0;
            irq_ena_q   <= '0;
            overrun_q   <= 1'b0;
            readdata_q  <= '0;
            expire_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            tick_pend_q <= tick_pend_d;
            load_q      <= load_d;
            count_q     <= count_d;
            en_q        <= en_d;
            per_q       <= per_d;
            status_q    <= status_d;
            irq_ena_q   <= irq_ena_d;
            overrun_q   <= overrun_d;
            readdata_q  <= readdata_d;
            expire_q    <= expire_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign expire       = expire_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_recon_delay_sched.sv
// Purpose: directed bench for recon_delay_sched with a queue-based scoreboard and negedge monitor.
// Latency: stimulus on posedge+1, all observation on negedge.
// Backpressure: n/a; every wait is a fixed cycle count, plus a global watchdog.
module tb_recon_delay_sched;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    localparam logic [1:0] K_RD    = 2'd0;
    localparam logic [1:0] K_IRQ   = 2'd1;
    localparam logic [1:0] K_EMPTY = 2'd2;
    localparam logic [1:0] K_EXP   = 2'd3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              millisec_tick = 1'b0;
    logic [NUM_CH-1:0] expire;
    logic              irq;

    recon_delay_sched_if bus ();

    recon_delay_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .millisec_tick (millisec_tick),
        .expire        (expire),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Expected expire pulses, in order of appearance
    logic [NUM_CH-1:0] x_q [$];
    string             xn_q [$];
    // Pending point checks
    logic [1:0]        k_q [$];
    logic [31:0]       e_q [$];
    string             n_q [$];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input logic [1:0] kind, input logic [31:0] exp, input string name);
        k_q.push_back(kind);
        e_q.push_back(exp);
        n_q.push_back(name);
    endtask

    task automatic push_exp(input logic [NUM_CH-1:0] mask, input string name);
        x_q.push_back(mask);
        xn_q.push_back(name);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        cyc(1);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        cyc(1);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        chk(K_RD, exp, name);
    endtask

    task automatic tick_n(input int n);
        millisec_tick = 1'b1;
        cyc(n);
        millisec_tick = 1'b0;
    endtask

    task automatic tick_scan();
        tick_n(1);
        cyc(8);
    endtask

    // Monitor: pops expected expire pulses and pending point checks.
    always @(negedge clk) begin
        logic [31:0] act;
        logic [31:0] ev;
        logic [1:0]  k;
        string       nm;
        if (reset_n && (expire != '0)) begin
            compared++;
            if (x_q.size() == 0) begin
                mismatched++;
                $display("FAIL expire_unexpected: got %h expected none", expire);
            end else begin
                nm = xn_q.pop_front();
                ev = 32'(x_q.pop_front());
                if (32'(expire) !== ev) begin
                    mismatched++;
                    $display("FAIL %s: got %h expected %h", nm, expire, ev[NUM_CH-1:0]);
                end
            end
        end
        while (k_q.size() > 0) begin
            k  = k_q.pop_front();
            ev = e_q.pop_front();
            nm = n_q.pop_front();
            case (k)
                K_RD:    act = bus.readdata;
                K_IRQ:   act = {31'd0, irq};
                K_EMPTY: act = 32'(x_q.size());
                default: act = 32'(expire);
            endcase
            compared++;
            if (act !== ev) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", nm, act, ev);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.writedata  = '0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        chk(K_IRQ, 32'd0, "rst_irq");
        chk(K_RD,  32'd0, "rst_readdata");
        chk(K_EXP, 32'd0, "rst_expire");

        // 1: reset while a scan is in flight that would otherwise expire ch0
        wr(5'd8, 32'd1);
        wr(5'd1, 32'd1);
        wr(5'd10, 32'd1);
        tick_n(1);
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        chk(K_IRQ, 32'd0, "t1_irq");
        rd(5'd0,  32'd0, "t1_status");
        rd(5'd1,  32'd0, "t1_irq_ena");
        rd(5'd8,  32'd0, "t1_load0");
        rd(5'd9,  32'd0, "t1_count0");
        rd(5'd10, 32'd0, "t1_ctrl0");

        // 2: one-shot on ch0, LOAD=3
        wr(5'd8, 32'd3);
        wr(5'd1, 32'd1);
        wr(5'd10, 32'd1);
        tick_scan();
        rd(5'd9, 32'd2, "t2_count_after_t1");
        tick_scan();
        push_exp(4'b0001, "t2_expire0");
        tick_scan();
        rd(5'd0, 32'd1, "t2_status");
        chk(K_IRQ, 32'd1, "t2_irq");
        rd(5'd10, 32'd0, "t2_ctrl_en_cleared");
        rd(5'd9,  32'd0, "t2_count_zero");
        wr(5'd0, 32'd1);
        chk(K_IRQ, 32'd1, "t2_irq_reg_latency");
        cyc(1);
        chk(K_IRQ, 32'd0, "t2_irq_cleared");

        // 3: periodic on ch2, LOAD=2
        wr(5'd1, 32'd0);
        wr(5'd16, 32'd2);
        wr(5'd18, 32'd3);
        rd(5'd17, 32'd2, "t3_count_init");
        for (int t = 1; t <= 6; t++) begin
            if ((t % 2) == 0) push_exp(4'b0100, $sformatf("t3_expire2_tick%0d", t));
            tick_scan();
            rd(5'd17, ((t % 2) == 0) ? 32'd2 : 32'd1, $sformatf("t3_count_tick%0d", t));
        end
        rd(5'd0, 32'h4, "t3_status");
        wr(5'd18, 32'd0);
        wr(5'd0, 32'hF);

        // 4: zero load on ch1 and load 1 on ch3 expire in the same scan
        wr(5'd12, 32'd0);
        wr(5'd14, 32'd1);
        wr(5'd20, 32'd1);
        wr(5'd22, 32'd1);
        push_exp(4'b0010, "t4_expire1");
        push_exp(4'b1000, "t4_expire3");
        tick_scan();
        rd(5'd0, 32'hA, "t4_status");
        wr(5'd0, 32'hF);

        // 5a: W1C of STATUS[0] lands in ch0's expiring scan cycle
        wr(5'd8, 32'd1);
        wr(5'd10, 32'd1);
        millisec_tick = 1'b1;
        cyc(1);
        millisec_tick = 1'b0;
        push_exp(4'b0001, "t5_expire0");
        wr(5'd0, 32'd1);
        cyc(8);
        rd(5'd0, 32'd1, "t5_status_set_wins");

        // 5b: CTRL write to ch0 in its scan cycle reloads without decrement
        wr(5'd8, 32'd5);
        wr(5'd10, 32'd1);
        millisec_tick = 1'b1;
        cyc(1);
        millisec_tick = 1'b0;
        wr(5'd10, 32'd1);
        cyc(8);
        rd(5'd9, 32'd5, "t5_cpu_write_wins");
        tick_scan();
        rd(5'd9, 32'd4, "t5_next_decrement");
        wr(5'd10, 32'd0);

        // 6: three back-to-back ticks -> two scans and OVERRUN
        wr(5'd0, 32'hFFFF_FFFF);
        wr(5'd12, 32'd10);
        wr(5'd14, 32'd1);
        tick_n(3);
        cyc(12);
        rd(5'd13, 32'd8, "t6_two_scans");
        rd(5'd0, 32'h8000_0000, "t6_overrun");
        rd(5'd5, 32'd0, "t6_unmapped_rd");
        wr(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, 32'd0, "t6_unmapped_wr_ignored");
        rd(5'd24, 32'd0, "t6_channel4_absent");
        wr(5'd0, 32'h8000_0000);
        rd(5'd0, 32'd0, "t6_overrun_cleared");
        wr(5'd14, 32'd0);

        cyc(2);
        chk(K_EMPTY, 32'd0, "expire_queue_drained");
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/recon_delay_sched.md
Name: recon_delay_sched

Overview:
- Multi-channel millisecond delay scheduler that shares the timer's single millisec_tick among NUM_CH software/hardware requesters.
- Each channel holds a one-shot or periodic countdown.
- One shared decrement datapath is time-multiplexed by a scan FSM that visits each channel once per tick.
- Sits beside recon_timer on the same Avalon-MM bus; raises a level IRQ and per-channel expiry pulses.

Parameters:
- NUM_CH, 4, number of channels (1..4).
- CNT_W, 32, countdown width in bits (≤32).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  5  Avalon word address
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- millisec_tick  in  1  one-cycle pulse from recon_timer
- expire  out  NUM_CH  one-cycle pulse per channel on expiry
- irq  out  1  level interrupt

Behaviour:
- Reset (async, reset_n low): all LOAD/COUNT/CTRL = 0; STATUS = 0; IRQ_ENA = 0; OVERRUN = 0; FSM = IDLE; tick_pend = 0; readdata = 0; expire = 0; irq = 0.
- Address map, global registers:
  - 0 STATUS: bits[NUM_CH-1:0] pending; bit 31 OVERRUN; write-1-to-clear.
  - 1 IRQ_ENA: RW, bits[NUM_CH-1:0].
- Address map, channel i at 8+4i:
  - +0 LOAD: RW, CNT_W bits.
  - +1 COUNT: RO.
  - +2 CTRL: RW; bit0 EN, bit1 PERIODIC.
- Unmapped addresses, or channels ≥ NUM_CH: read 0, writes ignored.
- Read latency: readdata is updated the cycle after chipselect&&read and holds until the next read.
- Writing CTRL with EN=1 copies LOAD into COUNT in the same cycle. A LOAD of 0 is treated as 1. Writing EN=0 freezes COUNT.
- FSM states and transitions:
  - IDLE: on millisec_tick or tick_pend → SCAN with ch_idx = 0; tick_pend cleared.
  - SCAN: process channel ch_idx, one channel per cycle. At ch_idx = NUM_CH-1 → IDLE. A full scan takes NUM_CH cycles.
- Channel processing (channel enabled):
  - COUNT > 1: COUNT ← COUNT-1.
  - COUNT ≤ 1, PERIODIC = 1: COUNT ← LOAD (0 → 1); STATUS[i] set; expire[i] pulses next cycle.
  - COUNT ≤ 1, PERIODIC = 0: COUNT ← 0; EN cleared; STATUS[i] set; expire[i] pulses next cycle.
  - Disabled channels are skipped (no change).
- Tick during SCAN: sets tick_pend, and a new scan starts right after the current one ends.
- Tick while tick_pend is already 1: tick is dropped and OVERRUN is set. This is not reachable when NUM_CH < clocks per ms.
- Simultaneous events:
  - CPU write to CTRL/LOAD of the channel being scanned in the same cycle: CPU write wins and the scan update is discarded.
  - W1C on STATUS[i] in the same cycle as a set of STATUS[i]: set wins.
- irq = |(STATUS[NUM_CH-1:0] & IRQ_ENA), registered (one cycle after STATUS/IRQ_ENA changes).
- Count arithmetic is unsigned CNT_W bits; no wrap below 0.

Decomposition:
- Package recon_sched_pkg:
  - Constants STATUS_OFFSET = 0, IRQ_ENA_OFFSET = 1, CH_BASE = 8, CH_STRIDE = 4, LOAD_OFF = 0, COUNT_OFF = 1, CTRL_OFF = 2.
  - Bit indices EN_BIT = 0, PERIODIC_BIT = 1, OVERRUN_BIT = 31.
  - FSM state encoding (IDLE, SCAN).
- No sub-module: the shared decrement datapath and the register bank are small enough for one module.

Test Plan:
1. Reset mid-scan: assert reset_n low during SCAN → all registers 0, irq = 0, FSM IDLE, and no expire pulse after release.
2. One-shot: ch0 LOAD = 3, IRQ_ENA = 1, CTRL = 1; apply 3 ticks → expire[0] pulses once after the 3rd tick's scan; STATUS = 1; irq = 1; CTRL.EN reads 0; COUNT = 0. Write STATUS = 1 → irq = 0 next cycle.
3. Periodic: ch2 LOAD = 2, CTRL = 3; apply 6 ticks → expire[2] pulses after ticks 2, 4 and 6; COUNT reads 2, 1, 2 … pattern.
4. Zero load plus concurrent channels: ch1 LOAD = 0, CTRL = 1, and ch3 LOAD = 1, CTRL = 1; apply 1 tick → expire[1] and expire[3] each pulse, in separate cycles of one scan; STATUS = 0xA.
5. Collisions: W1C of STATUS[0] in the same cycle ch0 expires → STATUS[0] remains 1. CTRL write to ch0 in the cycle it is scanned → COUNT = LOAD and no decrement.
6. Overrun: with NUM_CH = 4, drive ticks on 3 consecutive cycles → exactly 2 scans occur, STATUS bit 31 = 1, and reads of unmapped address 5 return 0.
